insfetch_queue: RTL and testbench

- Parametrised successor of the single-slot fetch stage.
- Requests instructions from the memory manager, computes the next PC, and buffers fetched {addr, ins} pairs in a DEPTH-entry FIFO.
- Feeds the decoder through a valid/ready handshake.
- Handles RVC length (+2/+4), JAL redirect, JALR stall until ROB resolve, HALT stall, and ROB flush with discard of an in-flight response.

---
 rtl/insfetch_queue_pkg.sv | 36 +++
 rtl/insfetch_queue_ins_fifo.sv | 72 +++++++
 rtl/insfetch_queue.sv | 184 ++++++++++++++++++
 tb/tb_insfetch_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insfetch_queue_pkg.sv
// Shared fetch-stage constants, FSM encoding and decode helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   OPC_JAL / OPC_JALR  major opcodes that redirect or stall fetch
//   HALT_INS_DEFAULT    encoding that parks fetch until resume or flush
//   fetch_state_t       RUN / WAIT / STUCK request-side FSM states
//   jal_imm()           unscrambles the J-type immediate
//   expand_rvc()        zero-extends a compressed instruction to 32 bits
package insfetch_queue_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_JALR         = 7'b1100111;
  localparam logic [31:0] HALT_INS_DEFAULT = 32'h0ff00513;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // free to issue when the queue has room
    ST_WAIT  = 2'd1,  // one request outstanding at the memory manager
    ST_STUCK = 2'd2   // JALR/HALT enqueued, waiting for the ROB to resolve it
  } fetch_state_t;

  // Takes instruction bits [31:12] and returns the signed byte offset of a JAL.
  // hi[19]=w[31], hi[18:9]=w[30:21], hi[8]=w[20], hi[7:0]=w[19:12].
  function automatic logic signed [20:0] jal_imm(input logic [19:0] hi);
    jal_imm = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

  // A word whose low two bits are not 2'b11 carries a 16-bit instruction in
  // its lower half; the upper half belongs to the next instruction.
  function automatic logic [31:0] expand_rvc(input logic [31:0] w);
    if (w[1:0] == 2'b11) expand_rvc = w;
    else                 expand_rvc = {16'h0000, w[15:0]};
  endfunction

endpackage

// File: rtl/insfetch_queue_ins_fifo.sv
// Generic DEPTH-entry synchronous FIFO holding fetched {addr, ins} pairs.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
//
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   push, push_dat   write one entry at the tail
//   pop              retire the head entry
//   clear            drop all entries (flush); wins over push/pop
//   full, empty      occupancy flags
//   count            number of valid entries, 0..DEPTH
//   head             entry at the read pointer (combinational)
module insfetch_queue_ins_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
      else if (!push_ok && pop_ok) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/insfetch_queue.sv
// Instruction fetch: issues requests, computes next PC, queues {addr, ins} for decode.
// Latency: a memory response is presented on is_ins the cycle after give_you.
// Backpressure: decoder stalls via dc_ready; fetch stops requesting while the queue is full.
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   rdy_in             global enable; all state holds while low
//   out_PC, ask_for    request address and level request to the memory manager
//   give_you(_ins)     one-cycle memory response and its raw 32-bit word
//   is_ins, ins_addr,
//   ins, dc_ready      valid/ready head-of-queue interface to the decoder
//   rob_clear          flush; empties the queue and redirects to rob_new_pc
//   cancel_stuck       JALR/HALT resolved; resume at rob_new_pc
module insfetch_queue
  import insfetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] HALT_INS = HALT_INS_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic [ADDR_W-1:0] out_PC,
  output logic              ask_for,
  input  logic              give_you,
  input  logic [31:0]       give_you_ins,
  output logic              is_ins,
  output logic [ADDR_W-1:0] ins_addr,
  output logic [31:0]       ins,
  input  logic              dc_ready,
  input  logic              rob_clear,
  input  logic [ADDR_W-1:0] rob_new_pc,
  input  logic              cancel_stuck
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam int unsigned EW = ADDR_W + 32;

  fetch_state_t      state;
  logic              drop;     // next response belongs to a flushed path
  logic [ADDR_W-1:0] pc;
  logic              ask_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;

  logic              is_rvc;
  logic              is_jal;
  logic              is_stop;
  logic [31:0]       ins_word;
  logic [ADDR_W-1:0] pc_next;
  logic              accept;
  logic              discard;
  logic [CW-1:0]     cnt_nxt;
  logic              room_next;

  // ---------------------------------------------------------------------------
  // Response decode
  // ---------------------------------------------------------------------------
  assign is_rvc   = (give_you_ins[1:0] != 2'b11);
  assign is_jal   = (give_you_ins[6:0] == OPC_JAL);
  // JALR target is only known in the backend; HALT parks fetch on purpose.
  assign is_stop  = (give_you_ins[6:0] == OPC_JALR) || (give_you_ins == HALT_INS);
  assign ins_word = expand_rvc(give_you_ins);

  always_comb begin
    pc_next = pc + (is_rvc ? ADDR_W'(2) : ADDR_W'(4));
    if (is_jal) pc_next = pc + ADDR_W'($signed(jal_imm(give_you_ins[31:12])));
  end

  // ask_q is high exactly while a request is issued and not yet answered, so a
  // response is only meaningful when it is set. Flush overrides both paths.
  assign accept  = give_you && ask_q && !drop && !fifo_full && !rob_clear;
  assign discard = give_you && ask_q && drop && !rob_clear;

  // ---------------------------------------------------------------------------
  // Queue
  // ---------------------------------------------------------------------------
  assign fifo_push  = rdy_in && accept;
  assign fifo_pop   = rdy_in && !fifo_empty && dc_ready && !rob_clear;
  assign fifo_clear = rdy_in && rob_clear;

  insfetch_queue_ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ins_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (fifo_push),
    .push_dat ({pc, ins_word}),
    .pop      (fifo_pop),
    .clear    (fifo_clear),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign is_ins   = !fifo_empty;
  assign ins_addr = fifo_head[EW-1:32];
  assign ins      = fifo_head[31:0];

  // Occupancy after this cycle's push/pop; a new request is only raised when
  // the queue will still have a free slot for its response.
  always_comb begin
    cnt_nxt = fifo_count;
    if (fifo_push && !fifo_pop)      cnt_nxt = fifo_count + CW'(1);
    else if (!fifo_push && fifo_pop) cnt_nxt = fifo_count - CW'(1);
  end

  assign room_next = (cnt_nxt < DEPTH_C);

  // ---------------------------------------------------------------------------
  // Request FSM and PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_RUN;
      drop  <= 1'b0;
      pc    <= '0;
      ask_q <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        pc <= rob_new_pc;
        if (ask_q && !give_you) begin
          // Memory still owes us a word for the old path: swallow it first.
          state <= ST_WAIT;
          drop  <= 1'b1;
          ask_q <= 1'b1;
        end else begin
          // Queue is empty after the clear, so there is always room.
          state <= ST_RUN;
          drop  <= 1'b0;
          ask_q <= 1'b1;
        end
      end else if (discard) begin
        drop  <= 1'b0;
        state <= ST_RUN;
        ask_q <= room_next;
      end else if (accept) begin
        if (is_stop) begin
          state <= ST_STUCK;
          ask_q <= 1'b0;
        end else begin
          pc    <= pc_next;
          state <= ST_RUN;
          ask_q <= room_next;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (ask_q) state <= ST_WAIT;
            else       ask_q <= room_next;
          end
          ST_WAIT: begin
            ask_q <= 1'b1;
          end
          ST_STUCK: begin
            if (cancel_stuck) begin
              pc    <= rob_new_pc;
              state <= ST_RUN;
              ask_q <= room_next;
            end
          end
          default: begin
            state <= ST_RUN;
            ask_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_PC  = pc;
  assign ask_for = ask_q;

endmodule

// File: tb/tb_insfetch_queue.sv
// Self-checking bench for insfetch_queue: directed scenarios then random traffic,
// all compared each cycle against a queue-based reference model.
module tb_insfetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] HALT   = 32'h0ff00513;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic [ADDR_W-1:0] out_PC;
  logic              ask_for;
  logic              give_you;
  logic [31:0]       give_you_ins;
  logic              is_ins;
  logic [ADDR_W-1:0] ins_addr;
  logic [31:0]       ins;
  logic              dc_ready;
  logic              rob_clear;
  logic [ADDR_W-1:0] rob_new_pc;
  logic              cancel_stuck;

  always #5 clk_in = ~clk_in;

  insfetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .HALT_INS (HALT)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .out_PC       (out_PC),
    .ask_for      (ask_for),
    .give_you     (give_you),
    .give_you_ins (give_you_ins),
    .is_ins       (is_ins),
    .ins_addr     (ins_addr),
    .ins          (ins),
    .dc_ready     (dc_ready),
    .rob_clear    (rob_clear),
    .rob_new_pc   (rob_new_pc),
    .cancel_stuck (cancel_stuck)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: fetched entries, fetch PC, and the request bookkeeping.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_ask;
  bit          m_stuck;
  bit          m_out;    // a request has been seen by memory and not answered
  bit          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] jal_off(input logic [31:0] w);
    int off;
    off = w[31] ? -(1 << 20) : 0;
    off = off + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
    return 32'(off);
  endfunction

  task automatic model_update();
    logic [31:0] w;
    bit          pop;
    if (rst_in) begin
      mq.delete();
      m_pc = '0; m_ask = 0; m_stuck = 0; m_out = 0; m_drop = 0;
      return;
    end
    if (!rdy_in) return;
    w   = give_you_ins;
    pop = (mq.size() != 0) && dc_ready;
    if (rob_clear) begin
      mq.delete();
      m_pc    = rob_new_pc;
      m_stuck = 0;
      m_drop  = m_ask && !give_you;
      m_out   = m_drop;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_ask && give_you) begin
        if (m_drop) begin
          m_drop = 0;
        end else begin
          mq.push_back({m_pc, (w[1:0] == 2'b11) ? w : {16'h0000, w[15:0]}});
          if (w[6:0] == 7'b1100111 || w == HALT) m_stuck = 1;
          else if (w[6:0] == 7'b1101111)         m_pc = m_pc + jal_off(w);
          else                                   m_pc = m_pc + ((w[1:0] == 2'b11) ? 32'd4 : 32'd2);
        end
        m_out = 0;
      end else begin
        if (m_ask) m_out = 1;
        if (m_stuck && cancel_stuck) begin
          m_stuck = 0;
          m_pc    = rob_new_pc;
        end
      end
    end
    m_ask = !m_stuck && (m_out || mq.size() < DEPTH);
  endtask

  task automatic check_all();
    chk("out_PC", 64'(out_PC), 64'(m_pc));
    chk("ask_for", 64'(ask_for), 64'(m_ask));
    chk("is_ins", 64'(is_ins), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("ins_addr", 64'(ins_addr), 64'(mq[0][63:32]));
      chk("ins", 64'(ins), 64'(mq[0][31:0]));
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_update();
    #1;
    check_all();
  endtask

  task automatic respond(input logic [31:0] w);
    int n;
    n = 0;
    while (!m_ask && n < 16) begin
      cyc();
      n++;
    end
    if (!m_ask) begin
      chk("ask_wait", 64'(ask_for), 64'(1));
      return;
    end
    give_you = 1'b1; give_you_ins = w;
    cyc();
    give_you = 1'b0; give_you_ins = '0;
  endtask

  task automatic clear_with_resp(input logic [31:0] npc);
    rob_clear = 1'b1; rob_new_pc = npc; give_you = 1'b1; give_you_ins = 32'h00000013;
    cyc();
    rob_clear = 1'b0; give_you = 1'b0; give_you_ins = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    rst_in = 1'b1; rdy_in = 1'b1; give_you = 1'b0; give_you_ins = '0;
    dc_ready = 1'b0; rob_clear = 1'b0; rob_new_pc = '0; cancel_stuck = 1'b0;
    m_pc = '0; m_ask = 0; m_stuck = 0; m_out = 0; m_drop = 0;

    // Reset state
    cyc(); cyc();
    chk("rst_ask_for", 64'(ask_for), 64'(0));
    chk("rst_is_ins", 64'(is_ins), 64'(0));
    chk("rst_ins_addr", 64'(ins_addr), 64'(0));
    chk("rst_ins", 64'(ins), 64'(0));
    chk("rst_out_PC", 64'(out_PC), 64'(0));
    rst_in = 1'b0;

    // Sequential 32-bit then compressed fetch
    respond(32'h00000013);
    chk("pc_after_addi", 64'(out_PC), 64'(4));
    respond(32'h00000001);
    chk("pc_after_cnop", 64'(out_PC), 64'(6));
    chk("head_addr0", 64'(ins_addr), 64'(0));
    chk("head_ins0", 64'(ins), 64'(32'h00000013));

    // Fill the queue with decoder stalled
    respond(32'h00000013);
    respond(32'h00000013);
    chk("full_ask_low", 64'(ask_for), 64'(0));
    chk("full_pc", 64'(out_PC), 64'(14));
    cyc(); cyc();
    chk("full_ask_hold", 64'(ask_for), 64'(0));
    give_you = 1'b1; give_you_ins = 32'h00000013;   // unsolicited word is ignored
    cyc();
    give_you = 1'b0; give_you_ins = '0;
    dc_ready = 1'b1;
    cyc();
    dc_ready = 1'b0;
    chk("pop_ask_back", 64'(ask_for), 64'(1));
    chk("pop_head_addr", 64'(ins_addr), 64'(4));
    chk("pop_head_ins", 64'(ins), 64'(32'h00000001));

    // Flush with a request outstanding: the late response is discarded
    cyc();
    rob_clear = 1'b1; rob_new_pc = 32'h40;
    cyc();
    rob_clear = 1'b0;
    chk("flush_pc", 64'(out_PC), 64'(32'h40));
    chk("flush_empty", 64'(is_ins), 64'(0));
    respond(32'h00000013);
    chk("drop_empty", 64'(is_ins), 64'(0));
    chk("drop_pc", 64'(out_PC), 64'(32'h40));
    cyc();

    // Same-cycle flush and response; then JAL redirect
    clear_with_resp(32'h8);
    chk("clr_resp_pc", 64'(out_PC), 64'(8));
    chk("clr_resp_empty", 64'(is_ins), 64'(0));
    respond(32'h0100006f);
    chk("jal_addr", 64'(ins_addr), 64'(8));
    chk("jal_ins", 64'(ins), 64'(32'h0100006f));
    chk("jal_target", 64'(out_PC), 64'(24));

    // JALR stalls until resolved
    clear_with_resp(32'h10);
    respond(32'h00008067);
    chk("jalr_ask", 64'(ask_for), 64'(0));
    chk("jalr_addr", 64'(ins_addr), 64'(32'h10));
    repeat (3) cyc();
    chk("jalr_pc_hold", 64'(out_PC), 64'(32'h10));
    cancel_stuck = 1'b1; rob_new_pc = 32'h200;
    cyc();
    cancel_stuck = 1'b0;
    chk("resume_pc", 64'(out_PC), 64'(32'h200));
    chk("resume_ask", 64'(ask_for), 64'(1));

    // HALT parks fetch; simultaneous flush and response redirects
    respond(HALT);
    repeat (8) cyc();
    chk("halt_ask", 64'(ask_for), 64'(0));
    clear_with_resp(32'h300);
    chk("halt_flush_pc", 64'(out_PC), 64'(32'h300));
    chk("halt_flush_empty", 64'(is_ins), 64'(0));

    // Global enable low: everything holds
    respond(32'h00000013);
    rdy_in = 1'b0; dc_ready = 1'b1; give_you = 1'b1; give_you_ins = 32'h00000013;
    rob_clear = 1'b1; rob_new_pc = 32'h500;
    repeat (3) cyc();
    chk("hold_pc", 64'(out_PC), 64'(32'h304));
    chk("hold_is_ins", 64'(is_ins), 64'(1));
    rdy_in = 1'b1; dc_ready = 1'b0; give_you = 1'b0; give_you_ins = '0; rob_clear = 1'b0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst_in     = (i == 750);
      rdy_in     = ($urandom_range(0, 9) != 0);
      dc_ready   = (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rob_clear  = ($urandom_range(0, 39) == 0);
      r          = $urandom;
      rob_new_pc = {22'h0, r[9:1], 1'b0};
      cancel_stuck = m_stuck ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      give_you   = m_ask ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
      r = $urandom;
      case ($urandom_range(0, 9))
        0:       w = HALT;
        1:       w = {r[31:7], 7'b1100111};
        2:       w = {r[31:7], 7'b1101111};
        3:       w = {r[31:2], 2'b00};
        4:       w = {r[31:2], 2'b01};
        5:       w = {r[31:2], 2'b10};
        default: w = {r[31:2], 2'b11};
      endcase
      give_you_ins = w;
      cyc();
    end

    rst_in = 1'b0; rdy_in = 1'b1; give_you = 1'b0; rob_clear = 1'b0; cancel_stuck = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
